// File: rtl/run_check_pkg.sv
// Shared types and helpers for the CPU run checker.
//   - run_state_e : checker FSM states
//   - cnt_w()     : width of a counter that must hold values 0..n
//   - DEF_SEED0/1 : default Fibonacci seeds
package run_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } run_state_e;

    localparam int DEF_SEED0 = 0;
    localparam int DEF_SEED1 = 1;

    // Bits needed to represent 0..n inclusive (never less than 1).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fib_term_gen.sv
// Fibonacci-style term generator. term_o is the term the CPU should print
// next; advance_i steps the pair (a,b) -> (b, a+b), with the sum wrapping
// modulo 2^DATA_W. load_i reloads the seeds and takes priority.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (reloads seeds)
//   load_i          reload a=SEED0, b=SEED1
//   advance_i       step to the next term
//   term_o          current expected term (register a)
module fib_term_gen
    import run_check_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] SEED0  = DATA_W'(DEF_SEED0),
    parameter logic [DATA_W-1:0] SEED1  = DATA_W'(DEF_SEED1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] term_o
);

    logic [DATA_W-1:0] a_q, b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q <= SEED0;
            b_q <= SEED1;
        end else if (load_i) begin
            a_q <= SEED0;
            b_q <= SEED1;
        end else if (advance_i) begin
            a_q <= b_q;
            b_q <= a_q + b_q;
        end
    end

    assign term_o = a_q;

endmodule

// File: rtl/cpu_run_checker.sv
// Run-control and result checker for single-cycle CPU bring-up.
// Holds the CPU in reset for RESET_CYCLES after start, then compares every
// printed value against a generated Fibonacci-style sequence. Reports a
// sticky pass after NUM_TERMS matches, or a sticky fail on the first
// mismatch or after TIMEOUT idle cycles without a print.
// Ports:
//   clock, reset     clock, async active-low reset
//   start            one-cycle pulse, starts a run from IDLE/PASS/FAIL
//   print_valid/data CPU print strobe and value
//   cpu_reset_n      active-low reset to the CPU
//   busy             in HOLD or RUN
//   pass/fail        sticky result flags; timeout marks a timeout fail
//   fail_index       index of the failing term
//   expected_data    expected term (frozen at the failing term on fail)
//   term_count       terms matched so far
module cpu_run_checker
    import run_check_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                NUM_TERMS    = 16,
    parameter int                RESET_CYCLES = 4,
    parameter int                TIMEOUT      = 4096,
    parameter logic [DATA_W-1:0] SEED0        = DATA_W'(DEF_SEED0),
    parameter logic [DATA_W-1:0] SEED1        = DATA_W'(DEF_SEED1),
    localparam int               CW           = cnt_w(NUM_TERMS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              print_valid,
    input  logic [DATA_W-1:0] print_data,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CW-1:0]     fail_index,
    output logic [DATA_W-1:0] expected_data,
    output logic [CW-1:0]     term_count
);

    localparam int HW = cnt_w(RESET_CYCLES);
    localparam int TW = cnt_w(TIMEOUT);

    run_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CW-1:0] tc_q, tc_d;
    logic [CW-1:0] fi_q, fi_d;
    logic          crn_q, crn_d;
    logic          busy_q, busy_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic          gen_load, gen_adv;
    logic [DATA_W-1:0] term;

    fib_term_gen #(
        .DATA_W (DATA_W),
        .SEED0  (SEED0),
        .SEED1  (SEED1)
    ) u_gen (
        .clk_i     (clock),
        .rst_ni    (reset),
        .load_i    (gen_load),
        .advance_i (gen_adv),
        .term_o    (term)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tmo_d      = tmo_q;
        tc_d       = tc_q;
        fi_d       = fi_q;
        crn_d      = crn_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        tmo_flag_d = tmo_flag_q;
        gen_load   = 1'b0;
        gen_adv    = 1'b0;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d    = ST_HOLD;
                    hold_d     = '0;
                    tmo_d      = '0;
                    tc_d       = '0;
                    fi_d       = '0;
                    crn_d      = 1'b0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    tmo_flag_d = 1'b0;
                    gen_load   = 1'b1;
                end
            end
            ST_HOLD: begin
                // Last hold cycle: release the CPU on the edge into RUN.
                if (hold_q == HW'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    crn_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                // A print on the expiry cycle takes priority over the timeout.
                if (print_valid) begin
                    if (print_data == term) begin
                        tc_d    = tc_q + 1'b1;
                        tmo_d   = '0;
                        gen_adv = 1'b1;
                        if (tc_d == CW'(NUM_TERMS)) begin
                            state_d = ST_PASS;
                            pass_d  = 1'b1;
                        end
                    end else begin
                        // Generator not advanced: expected_data stays on the bad term.
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                        fi_d    = tc_q;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d    = ST_FAIL;
                    fail_d     = 1'b1;
                    tmo_flag_d = 1'b1;
                    fi_d       = tc_q;
                    tmo_d      = tmo_q + 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_HOLD) || (state_d == ST_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            tmo_q      <= '0;
            tc_q       <= '0;
            fi_q       <= '0;
            crn_q      <= 1'b0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tmo_q      <= tmo_d;
            tc_q       <= tc_d;
            fi_q       <= fi_d;
            crn_q      <= crn_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign cpu_reset_n   = crn_q;
    assign busy          = busy_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign timeout       = tmo_flag_q;
    assign fail_index    = fi_q;
    assign term_count    = tc_q;
    assign expected_data = term;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Bench for cpu_run_checker. Four configurations share clock and reset:
//   k0: DATA_W=32 NUM_TERMS=10        (basic pass, mismatch, reset mid-run)
//   k1: DATA_W=8  NUM_TERMS=16        (mod-256 wrap)
//   k2: DATA_W=32 TIMEOUT=16          (timeout and expiry-cycle print)
//   k3: SEED0=2 SEED1=1 NUM_TERMS=5   (Lucas, start while busy / after pass)
module tb_cpu_run_checker;

    typedef struct {
        int          k;
        logic [31:0] data;
        int          exp_tc;
        bit          exp_pass;
        bit          exp_fail;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        st [4];
    logic        pv [4];
    logic [31:0] pd [4];

    logic        o_crn [4], o_busy [4], o_pass [4], o_fail [4], o_tmo [4];
    logic [7:0]  o_fi [4], o_tc [4];
    logic [31:0] o_exp [4];

    logic [3:0]  fi0, tc0;
    logic [4:0]  fi1, tc1, fi2, tc2;
    logic [2:0]  fi3, tc3;
    logic [7:0]  exp1;
    logic [31:0] exp0, exp2, exp3;

    int   total = 0;
    int   bad   = 0;
    vec_t vt [$];
    vec_t sb [$];

    always #5 clock = ~clock;

    cpu_run_checker #(.DATA_W(32), .NUM_TERMS(10), .RESET_CYCLES(4), .TIMEOUT(64)) u0 (
        .clock(clock), .reset(reset), .start(st[0]), .print_valid(pv[0]), .print_data(pd[0]),
        .cpu_reset_n(o_crn[0]), .busy(o_busy[0]), .pass(o_pass[0]), .fail(o_fail[0]),
        .timeout(o_tmo[0]), .fail_index(fi0), .expected_data(exp0), .term_count(tc0));

    cpu_run_checker #(.DATA_W(8), .NUM_TERMS(16), .RESET_CYCLES(4), .TIMEOUT(64)) u1 (
        .clock(clock), .reset(reset), .start(st[1]), .print_valid(pv[1]), .print_data(pd[1][7:0]),
        .cpu_reset_n(o_crn[1]), .busy(o_busy[1]), .pass(o_pass[1]), .fail(o_fail[1]),
        .timeout(o_tmo[1]), .fail_index(fi1), .expected_data(exp1), .term_count(tc1));

    cpu_run_checker #(.DATA_W(32), .NUM_TERMS(16), .RESET_CYCLES(4), .TIMEOUT(16)) u2 (
        .clock(clock), .reset(reset), .start(st[2]), .print_valid(pv[2]), .print_data(pd[2]),
        .cpu_reset_n(o_crn[2]), .busy(o_busy[2]), .pass(o_pass[2]), .fail(o_fail[2]),
        .timeout(o_tmo[2]), .fail_index(fi2), .expected_data(exp2), .term_count(tc2));

    cpu_run_checker #(.DATA_W(32), .NUM_TERMS(5), .RESET_CYCLES(4), .TIMEOUT(64),
                      .SEED0(32'd2), .SEED1(32'd1)) u3 (
        .clock(clock), .reset(reset), .start(st[3]), .print_valid(pv[3]), .print_data(pd[3]),
        .cpu_reset_n(o_crn[3]), .busy(o_busy[3]), .pass(o_pass[3]), .fail(o_fail[3]),
        .timeout(o_tmo[3]), .fail_index(fi3), .expected_data(exp3), .term_count(tc3));

    assign o_fi[0] = 8'(fi0);  assign o_tc[0] = 8'(tc0);  assign o_exp[0] = exp0;
    assign o_fi[1] = 8'(fi1);  assign o_tc[1] = 8'(tc1);  assign o_exp[1] = 32'(exp1);
    assign o_fi[2] = 8'(fi2);  assign o_tc[2] = 8'(tc2);  assign o_exp[2] = exp2;
    assign o_fi[3] = 8'(fi3);  assign o_tc[3] = 8'(tc3);  assign o_exp[3] = exp3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
        end
    endtask

    // Advance one full clock: inputs change and outputs are sampled at negedge.
    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pr(input int k, input logic [31:0] v);
        pv[k] = 1'b1;
        pd[k] = v;
        cyc();
        pv[k] = 1'b0;
    endtask

    // Count cycles cpu_reset_n stays low from the start edge; expect 4.
    task automatic wait_hold(input int k);
        int n = 0;
        while (!o_crn[k] && n < 20) begin
            n++;
            cyc();
        end
        chk("hold_cycles", 32'(n), 32'd4);
        chk("crn_in_run", 32'(o_crn[k]), 32'd1);
        chk("busy_in_run", 32'(o_busy[k]), 32'd1);
    endtask

    task automatic start_run(input int k);
        st[k] = 1'b1;
        cyc();
        st[k] = 1'b0;
        chk("start_busy", 32'(o_busy[k]), 32'd1);
        chk("start_pass_clr", 32'(o_pass[k]), 32'd0);
        chk("start_fail_clr", 32'(o_fail[k]), 32'd0);
        chk("start_tc_clr", 32'(o_tc[k]), 32'd0);
        wait_hold(k);
    endtask

    // Table rows: print, push expectation, pop and compare after the edge.
    task automatic apply(input int lo, input int hi);
        vec_t v, e;
        for (int i = lo; i <= hi; i++) begin
            v = vt[i];
            pv[v.k] = 1'b1;
            pd[v.k] = v.data;
            sb.push_back(v);
            cyc();
            pv[v.k] = 1'b0;
            e = sb.pop_front();
            chk($sformatf("row%0d_tc", i), 32'(o_tc[e.k]), 32'(e.exp_tc));
            chk($sformatf("row%0d_pass", i), 32'(o_pass[e.k]), 32'(e.exp_pass));
            chk($sformatf("row%0d_fail", i), 32'(o_fail[e.k]), 32'(e.exp_fail));
            repeat (4) cyc();
        end
    endtask

    function automatic vec_t mk(input int k, input logic [31:0] d, input int tc, input bit p, input bit f);
        vec_t v;
        v.k = k; v.data = d; v.exp_tc = tc; v.exp_pass = p; v.exp_fail = f;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fib8 [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
        int fib10 [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        int luc [5] = '{2, 1, 3, 4, 7};

        // rows 0..9: k0 full pass
        for (int i = 0; i < 10; i++) vt.push_back(mk(0, 32'(fib10[i]), i + 1, i == 9, 1'b0));
        // rows 10..14: k0 mismatch on term 4 (4 instead of 3)
        vt.push_back(mk(0, 32'd0, 1, 0, 0));
        vt.push_back(mk(0, 32'd1, 2, 0, 0));
        vt.push_back(mk(0, 32'd1, 3, 0, 0));
        vt.push_back(mk(0, 32'd2, 4, 0, 0));
        vt.push_back(mk(0, 32'd4, 4, 0, 1));
        // rows 15..30: k1 8-bit wrap
        for (int i = 0; i < 16; i++) vt.push_back(mk(1, 32'(fib8[i]), i + 1, i == 15, 1'b0));
        // rows 31..35: k3 Lucas
        for (int i = 0; i < 5; i++) vt.push_back(mk(3, 32'(luc[i]), i + 1, i == 4, 1'b0));

        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st[k] = 1'b0; pv[k] = 1'b0; pd[k] = '0;
        end
        repeat (3) cyc();

        // Reset values
        chk("rst_crn", 32'(o_crn[0]), 32'd0);
        chk("rst_busy", 32'(o_busy[0]), 32'd0);
        chk("rst_pass", 32'(o_pass[0]), 32'd0);
        chk("rst_fail", 32'(o_fail[0]), 32'd0);
        chk("rst_tmo", 32'(o_tmo[0]), 32'd0);
        chk("rst_fi", 32'(o_fi[0]), 32'd0);
        chk("rst_tc", 32'(o_tc[0]), 32'd0);
        chk("rst_exp0", o_exp[0], 32'd0);
        chk("rst_exp3", o_exp[3], 32'd2);
        reset = 1'b1;
        repeat (2) cyc();
        chk("idle_no_start_busy", 32'(o_busy[0]), 32'd0);

        // 1: basic pass
        start_run(0);
        apply(0, 9);
        chk("t1_tc", 32'(o_tc[0]), 32'd10);
        chk("t1_crn_after_pass", 32'(o_crn[0]), 32'd1);
        chk("t1_busy_after_pass", 32'(o_busy[0]), 32'd0);
        pr(0, 32'd99);
        chk("t1_pass_sticky", 32'(o_pass[0]), 32'd1);
        chk("t1_fail_ignored", 32'(o_fail[0]), 32'd0);

        // 2: mismatch
        start_run(0);
        apply(10, 14);
        chk("t2_fi", 32'(o_fi[0]), 32'd4);
        chk("t2_exp", o_exp[0], 32'd3);
        chk("t2_tmo", 32'(o_tmo[0]), 32'd0);
        pr(0, 32'd3);
        chk("t2_tc_frozen", 32'(o_tc[0]), 32'd4);
        chk("t2_fi_frozen", 32'(o_fi[0]), 32'd4);
        chk("t2_exp_frozen", o_exp[0], 32'd3);

        // 3: 8-bit wrap
        start_run(1);
        apply(15, 30);

        // 4: timeout on the 16th idle cycle
        start_run(2);
        pr(2, 32'd0);
        pr(2, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 15) chk("t4_no_fail_15", 32'(o_fail[2]), 32'd0);
        end
        chk("t4_fail", 32'(o_fail[2]), 32'd1);
        chk("t4_tmo", 32'(o_tmo[2]), 32'd1);
        chk("t4_fi", 32'(o_fi[2]), 32'd2);
        // 4b: print exactly on the expiry cycle wins and clears the counter
        start_run(2);
        chk("t4b_tmo_clr", 32'(o_tmo[2]), 32'd0);
        pr(2, 32'd0);
        pr(2, 32'd1);
        repeat (15) cyc();
        pr(2, 32'd1);
        chk("t4b_no_fail", 32'(o_fail[2]), 32'd0);
        chk("t4b_tc", 32'(o_tc[2]), 32'd3);
        repeat (15) cyc();
        chk("t4b_no_fail_15", 32'(o_fail[2]), 32'd0);
        cyc();
        chk("t4b_fail_16", 32'(o_fail[2]), 32'd1);
        chk("t4b_fi", 32'(o_fi[2]), 32'd3);

        // 5: asynchronous reset mid-run
        start_run(0);
        pr(0, 32'd0);
        pr(0, 32'd1);
        pr(0, 32'd1);
        chk("t5_tc3", 32'(o_tc[0]), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("t5_crn", 32'(o_crn[0]), 32'd0);
        chk("t5_busy", 32'(o_busy[0]), 32'd0);
        chk("t5_tc", 32'(o_tc[0]), 32'd0);
        chk("t5_exp", o_exp[0], 32'd0);
        chk("t5_fail2", 32'(o_fail[2]), 32'd0);
        chk("t5_fi2", 32'(o_fi[2]), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();
        start_run(0);
        apply(0, 9);

        // 6: start while busy ignored; restart after pass
        start_run(3);
        apply(31, 32);
        st[3] = 1'b1;
        cyc();
        st[3] = 1'b0;
        chk("t6_busy", 32'(o_busy[3]), 32'd1);
        chk("t6_crn", 32'(o_crn[3]), 32'd1);
        chk("t6_tc", 32'(o_tc[3]), 32'd2);
        apply(33, 35);
        st[3] = 1'b1;
        cyc();
        st[3] = 1'b0;
        chk("t6_re_pass", 32'(o_pass[3]), 32'd0);
        chk("t6_re_tc", 32'(o_tc[3]), 32'd0);
        chk("t6_re_crn", 32'(o_crn[3]), 32'd0);
        chk("t6_re_exp", o_exp[3], 32'd2);
        wait_hold(3);
        apply(31, 35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_checker.md
Name: cpu_run_checker

Overview:
Synthesizable run-control and result checker for single-cycle CPU bring-up. Successor to the fixed-width Fibonacci bench harness.
- Sequences the CPU's reset, then watches the CPU's print strobe/data.
- Compares each printed value against an internally generated Fibonacci-style sequence (parametrised width, seeds, term count).
- Reports pass, fail, first-mismatch index and timeout.
- Sits beside the CPU top in both simulation and on-board bring-up.

Parameters:
DATA_W, 32, width of print_data and sequence arithmetic
NUM_TERMS, 16, number of correct terms required for pass (>=1)
RESET_CYCLES, 4, cycles cpu_reset_n held low after start (>=1)
TIMEOUT, 4096, max idle cycles between print strobes in RUN (>=2)
SEED0, 0, first expected term
SEED1, 1, second expected term

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE/PASS/FAIL
print_valid  in  1  CPU print strobe; one term per asserted cycle
print_data  in  DATA_W  CPU printed value
cpu_reset_n  out  1  active-low reset driven to CPU
busy  out  1  high in HOLD or RUN
pass  out  1  sticky pass flag
fail  out  1  sticky fail flag
timeout  out  1  sticky; fail was caused by timeout
fail_index  out  CW  term index of first mismatch, CW = clog2(NUM_TERMS+1)
expected_data  out  DATA_W  expected value at fail_index (current expected term otherwise)
term_count  out  CW  number of terms matched so far

Behaviour:
- Reset (reset=0, async): state IDLE; cpu_reset_n=0; busy/pass/fail/timeout=0; fail_index=0; term_count=0; expected regs a=SEED0, b=SEED1; hold counter and timeout counter = 0.
- States: IDLE, HOLD, RUN, PASS, FAIL.
- IDLE/PASS/FAIL + start:
  - Go to HOLD.
  - Clear pass/fail/timeout/term_count/fail_index.
  - Reload a=SEED0, b=SEED1.
  - cpu_reset_n=0.
- HOLD:
  - Counts RESET_CYCLES cycles with cpu_reset_n=0.
  - Then enters RUN; cpu_reset_n=1 registered on the first RUN cycle.
- RUN, print_valid=1:
  - Compare print_data with a (registered, result acted on the same edge).
  - Match: term_count+1; (a,b) <= (b, a+b mod 2^DATA_W); timeout counter cleared. If the new term_count == NUM_TERMS, next state is PASS.
  - Mismatch: next state FAIL; fail_index=term_count; expected_data frozen at a.
- RUN, print_valid=0:
  - Timeout counter increments.
  - At TIMEOUT idle cycles: FAIL with timeout=1; fail_index=term_count.
- Simultaneous print_valid and timeout expiry: print_valid wins; the counter clears.
- PASS/FAIL:
  - Sticky; cpu_reset_n stays 1 (CPU keeps running).
  - print_valid ignored; only start or reset leaves.
- Ignored inputs: start while busy; print_valid outside RUN.
- Addition wraps modulo 2^DATA_W with no overflow flag; the CPU is expected to wrap identically.
- Reset asserted mid-run: immediate return to the reset values above, including cpu_reset_n=0.
- Outputs: all registered; no combinational path from inputs to outputs.
- Latency: pass/fail visible 1 cycle after the deciding print_valid edge.

Decomposition:
- Shared package (run_check_pkg):
  - state enum {IDLE, HOLD, RUN, PASS, FAIL}
  - CW width function (clog2)
  - default seed constants
- Sub-module: fib_term_gen
  - Holds a, b.
  - Inputs: load, advance; outputs the current term.
  - Parametrised by DATA_W, SEED0, SEED1.
- The FSM, counters and compare stay in cpu_run_checker.

Test Plan:
1. DATA_W=32, NUM_TERMS=10: start, then prints 0,1,1,2,3,5,8,13,21,34, one every 5 cycles -> cpu_reset_n low exactly 4 cycles; pass=1 one cycle after 34; term_count=10; fail=0.
2. Mismatch: prints 0,1,1,2,4 -> fail=1, fail_index=4, expected_data=3, timeout=0; later prints ignored.
3. DATA_W=8, NUM_TERMS=16: prints up to 233, then 121, then 98 -> pass=1, which proves the mod-256 wrap.
4. TIMEOUT=16: prints 0,1, then silence -> fail=1, timeout=1, fail_index=2, asserted on the 16th idle cycle. A variant with print_valid on exactly the expiry cycle -> no fail.
5. Reset low mid-RUN after 3 terms -> all outputs return to reset values asynchronously. A following start produces a clean run that passes.
6. start pulsed during RUN -> ignored. start after PASS -> flags clear and HOLD re-enters with a=SEED0. SEED0=2, SEED1=1 (Lucas sequence): prints 2,1,3,4,7 -> pass with NUM_TERMS=5.
